// File: rtl/z80_vdp99_core.sv
// CPU-facing core of a TMS9918-style VDP: 16 KB VRAM, data/control port protocol,
// R0..R7, status/frame interrupt, and a VGA sync generator that shows the backdrop colour.
module z80_vdp99_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       phi,
    input  logic       reset,
    input  logic       cpu_mode,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    output logic [3:0] color,
    output logic       hsync,
    output logic       vsync,
    output logic       irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    // ---------------------------------------------------------------
    // CPU strobe edge detection and access decode
    // ---------------------------------------------------------------
    logic       wr_prev_reg;
    logic       rd_prev_reg;
    logic       wr_edge;
    logic       rd_edge;
    logic       ctrl_wr;
    logic       data_wr;
    logic       data_rd;
    logic       stat_rd;
    logic       reg_we;
    logic [2:0] reg_sel;

    assign wr_edge = cpu_wr & ~wr_prev_reg;
    assign rd_edge = cpu_rd & ~rd_prev_reg;
    assign ctrl_wr = wr_edge &  cpu_mode;
    assign data_wr = wr_edge & ~cpu_mode;
    assign stat_rd = rd_edge &  cpu_mode;
    assign data_rd = rd_edge & ~cpu_mode;

    // ---------------------------------------------------------------
    // Port state: address, byte toggle, latch, read-ahead buffer
    // ---------------------------------------------------------------
    logic        toggle_reg;
    logic [7:0]  latch_reg;
    logic [13:0] addr_reg;
    logic [7:0]  read_buf_reg;
    logic [7:0]  dout_reg;
    logic        fetch_pend_reg;
    logic        fetch_load_reg;
    logic        f_reg;
    logic        irq_reg;
    logic [7:0]  vram_q;

    assign reg_we  = ctrl_wr & toggle_reg & cpu_din[7];
    assign reg_sel = cpu_din[2:0];

    // Prefetch is a two-step pipeline: the RAM reads addr_reg in the cycle
    // fetch_pend_reg is high, and the buffer takes vram_q one cycle later.
    always_ff @(posedge phi) begin
        if (!reset) begin
            wr_prev_reg    <= 1'b0;
            rd_prev_reg    <= 1'b0;
            toggle_reg     <= 1'b0;
            latch_reg      <= 8'h00;
            addr_reg       <= 14'h0000;
            read_buf_reg   <= 8'h00;
            dout_reg       <= 8'h00;
            fetch_pend_reg <= 1'b0;
            fetch_load_reg <= 1'b0;
        end else begin
            wr_prev_reg    <= cpu_wr;
            rd_prev_reg    <= cpu_rd;
            fetch_pend_reg <= 1'b0;
            fetch_load_reg <= fetch_pend_reg;

            if (fetch_pend_reg) begin
                addr_reg <= addr_reg + 14'd1;
            end
            if (fetch_load_reg) begin
                read_buf_reg <= vram_q;
            end

            if (ctrl_wr) begin
                if (!toggle_reg) begin
                    latch_reg  <= cpu_din;
                    toggle_reg <= 1'b1;
                end else begin
                    toggle_reg <= 1'b0;
                    if (!cpu_din[7]) begin
                        addr_reg <= {cpu_din[5:0], latch_reg};
                        if (!cpu_din[6]) begin
                            fetch_pend_reg <= 1'b1;
                        end
                    end
                end
            end

            if (data_wr) begin
                read_buf_reg <= cpu_din;
                addr_reg     <= addr_reg + 14'd1;
                toggle_reg   <= 1'b0;
            end

            if (data_rd) begin
                dout_reg       <= read_buf_reg;
                fetch_pend_reg <= 1'b1;
                toggle_reg     <= 1'b0;
            end

            if (stat_rd) begin
                dout_reg   <= {f_reg, 7'b0};
                toggle_reg <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // VRAM: 16K x 8, single port, registered read
    // ---------------------------------------------------------------
    logic [7:0] vram [0:16383];

    always_ff @(posedge phi) begin
        if (data_wr && reset) begin
            vram[addr_reg] <= cpu_din;
        end
        vram_q <= vram[addr_reg];
    end

    // ---------------------------------------------------------------
    // Write-only registers R0..R7
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [7:0] value_reg;
            always_ff @(posedge phi) begin
                if (!reset) begin
                    value_reg <= 8'h00;
                end else if (reg_we && (reg_sel == 3'(gi))) begin
                    value_reg <= latch_reg;
                end
            end
        end
    endgenerate

    logic [7:0] r1;
    logic [7:0] r7;
    logic       unused_reg_bits;

    assign r1 = g_reg[1].value_reg;
    assign r7 = g_reg[7].value_reg;
    // Mode and table-base bits belong to the renderer; nothing here reads them.
    assign unused_reg_bits = ^{g_reg[0].value_reg, r1[7], r1[4:0], g_reg[2].value_reg,
                               g_reg[3].value_reg, g_reg[4].value_reg, g_reg[5].value_reg,
                               g_reg[6].value_reg, r7[7:4]};

    // ---------------------------------------------------------------
    // Video timing, sync and backdrop colour
    // ---------------------------------------------------------------
    logic [HW-1:0] hcount_reg;
    logic [VW-1:0] vcount_reg;
    logic          hsync_reg;
    logic          vsync_reg;
    logic [3:0]    color_reg;
    logic          active;
    logic          frame_set;

    assign active    = (hcount_reg < H_ACT_END) && (vcount_reg < V_ACT_END);
    assign frame_set = (hcount_reg == H_LAST) && (vcount_reg == V_ACT_LAST);

    always_ff @(posedge phi) begin
        if (!reset) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
            hsync_reg  <= 1'b1;
            vsync_reg  <= 1'b1;
            color_reg  <= 4'h0;
        end else begin
            if (hcount_reg == H_LAST) begin
                hcount_reg <= '0;
                vcount_reg <= (vcount_reg == V_LAST) ? '0 : vcount_reg + VW'(1);
            end else begin
                hcount_reg <= hcount_reg + HW'(1);
            end
            hsync_reg <= ~((hcount_reg >= HS_START) && (hcount_reg < HS_END));
            vsync_reg <= ~((vcount_reg >= VS_START) && (vcount_reg < VS_END));
            color_reg <= (active && r1[6]) ? r7[3:0] : 4'h0;
        end
    end

    // ---------------------------------------------------------------
    // Frame flag and interrupt; a frame set coinciding with a status read wins
    // ---------------------------------------------------------------
    always_ff @(posedge phi) begin
        if (!reset) begin
            f_reg   <= 1'b0;
            irq_reg <= 1'b0;
        end else begin
            if (frame_set) begin
                f_reg <= 1'b1;
            end else if (stat_rd) begin
                f_reg <= 1'b0;
            end
            irq_reg <= f_reg & r1[5];
        end
    end

    assign cpu_dout = dout_reg;
    assign color    = color_reg;
    assign hsync    = hsync_reg;
    assign vsync    = vsync_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_z80_vdp99_core.sv
// Bench for z80_vdp99_core: directed protocol cases plus randomized port traffic,
// checked against a transaction-level model of the VDP port and a pixel-position model.
module tb_z80_vdp99_core;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;

    logic       phi = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_mode = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd = 1'b0;
    logic [7:0] cpu_dout;
    logic [3:0] color;
    logic       hsync;
    logic       vsync;
    logic       irq;

    z80_vdp99_core #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .phi(phi), .reset(reset), .cpu_mode(cpu_mode), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .color(color), .hsync(hsync), .vsync(vsync), .irq(irq)
    );

    always #5 phi = ~phi;

    // clocks since reset release = current pixel position of the DUT counters
    int n;
    always @(posedge phi) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    int checks = 0;
    int failures = 0;

    // port model
    int         addr_m;
    bit         tog_m;
    logic [7:0] latch_m;
    logic [7:0] regs_m [8];
    logic [7:0] mem_m [int];
    logic [7:0] rbuf_m;
    bit         rbuf_known;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic mode, input logic [7:0] d);
        cpu_mode = mode; cpu_din = d; cpu_wr = 1'b1;
        @(negedge phi); @(negedge phi);
        cpu_wr = 1'b0;
        @(negedge phi); @(negedge phi);
    endtask

    task automatic bus_read(input logic mode, output logic [7:0] d);
        cpu_mode = mode; cpu_rd = 1'b1;
        @(negedge phi);
        d = cpu_dout;
        @(negedge phi);
        cpu_rd = 1'b0;
        @(negedge phi); @(negedge phi);
    endtask

    function automatic void fetch_model();
        if (mem_m.exists(addr_m)) begin
            rbuf_m = mem_m[addr_m];
            rbuf_known = 1'b1;
        end else begin
            rbuf_known = 1'b0;
        end
        addr_m = (addr_m + 1) % 16384;
    endfunction

    task automatic ctrl_wr(input logic [7:0] d);
        bus_write(1'b1, d);
        $display("txn ctrl_wr %02h", d);
        if (!tog_m) begin
            latch_m = d;
            tog_m = 1'b1;
        end else begin
            tog_m = 1'b0;
            if (d[7]) begin
                regs_m[d[2:0]] = latch_m;
            end else begin
                addr_m = int'(d[5:0]) * 256 + int'(latch_m);
                if (!d[6]) fetch_model();
            end
        end
    endtask

    task automatic data_wr(input logic [7:0] d);
        bus_write(1'b0, d);
        $display("txn data_wr addr=%04h %02h", addr_m, d);
        mem_m[addr_m] = d;
        rbuf_m = d;
        rbuf_known = 1'b1;
        addr_m = (addr_m + 1) % 16384;
        tog_m = 1'b0;
    endtask

    task automatic data_rd(output logic [7:0] got);
        bus_read(1'b0, got);
        $display("txn data_rd %02h", got);
        if (rbuf_known) check_val("data_rd", got, rbuf_m);
        fetch_model();
        tog_m = 1'b0;
    endtask

    task automatic stat_rd(output logic [7:0] got);
        bus_read(1'b1, got);
        $display("txn stat_rd %02h", got);
        tog_m = 1'b0;
    endtask

    task automatic set_addr(input int a, input bit for_write);
        logic [13:0] av;
        av = 14'(a);
        ctrl_wr(av[7:0]);
        ctrl_wr({1'b0, for_write, av[13:8]});
    endtask

    task automatic set_reg(input int r, input logic [7:0] v);
        ctrl_wr(v);
        ctrl_wr(8'h80 | 8'(r));
    endtask

    // compare sync and colour against the pixel position one clock back
    task automatic scan_video(input int cycles, input string tag);
        int bad_c, bad_h, bad_v, seen;
        int p, h, v;
        logic [3:0] ec;
        bad_c = 0; bad_h = 0; bad_v = 0; seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge phi);
            p = n - 1;
            h = p % HT;
            v = (p / HT) % VT;
            ec = (h < HA && v < VA && regs_m[1][6]) ? regs_m[7][3:0] : 4'h0;
            if (color != ec) bad_c++;
            if (ec != 4'h0 && color == ec) seen++;
            if (hsync != !(h >= HA + HFP && h < HA + HFP + HS)) bad_h++;
            if (vsync != !(v >= VA + VFP && v < VA + VFP + VS)) bad_v++;
        end
        $display("txn scan %s cycles=%0d bad=%0d/%0d/%0d", tag, cycles, bad_c, bad_h, bad_v);
        check_val({tag, "_color"}, bad_c, 0);
        check_val({tag, "_hsync"}, bad_h, 0);
        check_val({tag, "_vsync"}, bad_v, 0);
        if (regs_m[1][6] && regs_m[7][3:0] != 4'h0) check_val({tag, "_color_seen"}, int'(seen > 0), 1);
    endtask

    initial begin
        logic [7:0] got;
        bit         found;
        logic       prev_vs;

        // reset held 4 clocks
        repeat (4) @(negedge phi);
        check_val("rst_hsync", hsync, 1);
        check_val("rst_vsync", vsync, 1);
        reset = 1'b1;
        @(negedge phi);
        check_val("rel_hsync", hsync, 1);
        check_val("rel_vsync", vsync, 1);
        check_val("rel_irq", irq, 0);
        check_val("rel_dout", cpu_dout, 0);
        check_val("rel_color", color, 0);
        addr_m = 0; tog_m = 1'b0; latch_m = 8'h00; rbuf_m = 8'h00; rbuf_known = 1'b1;
        for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;

        // backdrop colour over a full frame
        ctrl_wr(8'h34); ctrl_wr(8'h87);
        set_reg(1, 8'h60);
        scan_video(FR + 40, "bd");

        // VRAM write/read through the data port
        ctrl_wr(8'h00); ctrl_wr(8'h48);
        data_wr(8'hAA); data_wr(8'h55);
        ctrl_wr(8'h00); ctrl_wr(8'h08);
        data_rd(got); check_val("rd_0800", got, 8'hAA);
        data_rd(got); check_val("rd_0801", got, 8'h55);

        // address wrap
        set_addr(16'h3FFF, 1'b1);
        data_wr(8'h11); data_wr(8'h22);
        set_addr(16'h3FFF, 1'b0);
        data_rd(got); check_val("rd_3fff", got, 8'h11);
        data_rd(got); check_val("rd_wrap0", got, 8'h22);

        // frame interrupt and status clear
        found = 1'b0;
        prev_vs = vsync;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            @(negedge phi);
            if (prev_vs && !vsync) found = 1'b1;
            prev_vs = vsync;
        end
        check_val("vsync_fall_seen", found, 1);
        check_val("irq_at_vsync", irq, 1);
        stat_rd(got); check_val("stat_f1", got, 8'h80);
        check_val("irq_cleared", irq, 0);
        stat_rd(got); check_val("stat_f0", got, 8'h00);

        // status read on the very clock F is set: old value returned, F stays set
        found = 1'b0;
        for (int i = 0; i < FR + 10 && !found; i++) begin
            if (n % FR == VA * HT - 1) found = 1'b1;
            else @(negedge phi);
        end
        check_val("f_edge_reached", found, 1);
        stat_rd(got); check_val("stat_coincide", got, 8'h00);
        check_val("irq_after_coincide", irq, 1);
        set_reg(1, 8'h40);
        check_val("irq_ie_off", irq, 0);
        stat_rd(got); check_val("stat_set_wins", got, 8'h80);
        set_reg(1, 8'h60);

        // half-written control pair is abandoned by a status read
        ctrl_wr(8'h12);
        stat_rd(got);
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(8'h5A);
        ctrl_wr(8'h00); ctrl_wr(8'h00);
        data_rd(got); check_val("toggle_reset", got, 8'h5A);

        // randomized traffic around the address wrap
        for (int k = 0; k < 200; k++) begin
            int op;
            op = int'($urandom_range(0, 7));
            case (op)
                0: set_addr((16'h3FF8 + int'($urandom_range(0, 15))) % 16384, 1'b1);
                1: set_addr((16'h3FF8 + int'($urandom_range(0, 15))) % 16384, 1'b0);
                2, 3: data_wr(8'($urandom));
                4, 5: data_rd(got);
                6: set_reg(int'($urandom_range(0, 7)), 8'($urandom));
                default: begin
                    if ($urandom_range(0, 1) == 0) stat_rd(got);
                    else ctrl_wr(8'($urandom));
                end
            endcase
        end
        scan_video(600, "rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
